// File: rtl/inst_prefetch_pkg.sv
// Shared types and helpers for the instruction prefetch unit.
package inst_prefetch_pkg;

  localparam int ADDR_W  = 32;
  localparam int INST_W  = 32;
  localparam int ENTRY_W = ADDR_W + INST_W;

  typedef enum logic [1:0] {
    PF_IDLE  = 2'd0,
    PF_REQ   = 2'd1,
    PF_DRAIN = 2'd2
  } pf_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } pf_entry_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_prefetch_fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, inst} entries; head is read straight
// from the storage registers and reads as zero while empty.
module inst_prefetch_fetch_fifo
  import inst_prefetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clr,
  input  logic [ENTRY_W-1:0]       din,
  output logic [ENTRY_W-1:0]       dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [PW:0]        cnt;
  logic               do_push;
  logic               do_pop;

  // clear dominates both push and pop in the same cycle
  assign do_push = push && !full && !clr;
  assign do_pop  = pop && !empty && !clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (PW+1)'(1);
        2'b01:   cnt <= cnt - (PW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign full  = (cnt == (PW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign dout  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/inst_prefetch.sv
// Instruction prefetch: keeps one sequential fetch outstanding to instruction
// memory and queues the returned words for the core; flush redirects fetch.
module inst_prefetch
  import inst_prefetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        core_valid_o,
  input  logic        core_ready_i,
  output logic [31:0] core_pc_o,
  output logic [31:0] core_inst_o,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int CW = $clog2(DEPTH) + 1;

  pf_state_t   state, state_next;
  logic [31:0] fetch_pc, fetch_pc_next;
  logic [31:0] drain_addr, drain_addr_next;
  logic        push, pop, full, empty;
  logic [CW-1:0] count;
  logic [CW:0]   count_after;
  logic [ENTRY_W-1:0] head_raw;
  pf_entry_t   head, push_entry;

  assign pop         = core_valid_o && core_ready_i;
  assign push        = (state == PF_REQ) && mem_ack_i && !flush_i;
  assign count_after = {1'b0, count} + (CW+1)'(1) - (CW+1)'(pop);
  assign push_entry  = '{pc: fetch_pc, inst: mem_rdata_i};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= PF_IDLE;
      fetch_pc   <= RESET_PC;
      drain_addr <= '0;
    end else begin
      state      <= state_next;
      fetch_pc   <= fetch_pc_next;
      drain_addr <= drain_addr_next;
    end
  end

  always_comb begin
    state_next      = state;
    fetch_pc_next   = fetch_pc;
    drain_addr_next = drain_addr;
    mem_req_o       = 1'b0;
    mem_addr_o      = '0;
    case (state)
      PF_IDLE: begin
        // a pop this cycle frees a slot, so a full queue can restart at once
        if (flush_i)             fetch_pc_next = word_align(flush_pc_i);
        else if (!full || pop)   state_next    = PF_REQ;
      end
      PF_REQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = fetch_pc;
        if (mem_ack_i) begin
          if (flush_i) begin
            fetch_pc_next = word_align(flush_pc_i);
            state_next    = PF_IDLE;
          end else begin
            fetch_pc_next = fetch_pc + 32'd4;
            state_next    = (count_after < (CW+1)'(DEPTH)) ? PF_REQ : PF_IDLE;
          end
        end else if (flush_i) begin
          // request cannot be withdrawn: finish it at the old address, discard data
          drain_addr_next = fetch_pc;
          fetch_pc_next   = word_align(flush_pc_i);
          state_next      = PF_DRAIN;
        end
      end
      PF_DRAIN: begin
        mem_req_o  = 1'b1;
        mem_addr_o = drain_addr;
        if (flush_i)   fetch_pc_next = word_align(flush_pc_i);
        if (mem_ack_i) state_next    = PF_IDLE;
      end
      default: state_next = PF_IDLE;
    endcase
  end

  inst_prefetch_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clr   (flush_i),
    .din   (push_entry),
    .dout  (head_raw),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign head         = head_raw;
  assign core_valid_o = !empty;
  assign core_pc_o    = head.pc;
  assign core_inst_o  = head.inst;

endmodule

// File: tb/tb_inst_prefetch.sv
// Self-checking bench for inst_prefetch: vector table, directed corner cases
// and a randomized run against a transaction-level queue model.
module tb_inst_prefetch;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_valid, core_ready, flush, mem_req, mem_ack;
  logic [31:0] core_pc, core_inst, flush_pc, mem_addr, mem_rdata;

  always #5 clk = ~clk;

  inst_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .core_valid_o (core_valid),
    .core_ready_i (core_ready),
    .core_pc_o    (core_pc),
    .core_inst_o  (core_inst),
    .flush_i      (flush),
    .flush_pc_i   (flush_pc),
    .mem_req_o    (mem_req),
    .mem_addr_o   (mem_addr),
    .mem_ack_i    (mem_ack),
    .mem_rdata_i  (mem_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  // reference model: the queue as the core should see it
  ent_t        mq[$];
  logic [31:0] exp_fetch;
  bit          tainted;
  bit          prev_req, prev_ack;
  logic [31:0] prev_addr;
  int          req_age;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_fetch = RESET_PC;
    tainted   = 1'b0;
    prev_req  = 1'b0;
    prev_ack  = 1'b0;
    prev_addr = '0;
    req_age   = 0;
  endtask

  task automatic model_check();
    chk("valid", core_valid, mq.size() > 0);
    chk("head_pc", core_pc, (mq.size() > 0) ? mq[0].pc : 32'h0);
    chk("head_inst", core_inst, (mq.size() > 0) ? mq[0].inst : 32'h0);
    if (prev_req && !prev_ack) begin
      chk("req_hold", mem_req, 1);
      chk("addr_hold", mem_addr, prev_addr);
    end
    if (mem_req && !tainted) chk("room", mq.size() < DEPTH, 1);
    if (mem_req) chk("addr_align", mem_addr[1:0], 0);
  endtask

  // apply one cycle of inputs, advance the model, clock, then check
  task automatic step(input bit rdy, input bit fl, input logic [31:0] fpc, input bit ack_en);
    core_ready = rdy;
    flush      = fl;
    flush_pc   = fpc;
    mem_ack    = ack_en && mem_req;
    mem_rdata  = mem_ack ? mem_word(mem_addr) : $urandom();
    prev_req   = mem_req;
    prev_addr  = mem_addr;
    prev_ack   = mem_ack;
    req_age    = (mem_req && !mem_ack) ? req_age + 1 : 0;
    if (fl) begin
      tainted   = mem_req && !mem_ack;
      mq.delete();
      exp_fetch = {fpc[31:2], 2'b00};
    end else begin
      if (core_valid && rdy && mq.size() > 0) void'(mq.pop_front());
      if (mem_ack) begin
        if (tainted) tainted = 1'b0;
        else begin
          chk("fetch_addr", mem_addr, exp_fetch);
          mq.push_back('{mem_addr, mem_rdata});
          exp_fetch = exp_fetch + 32'd4;
        end
      end
    end
    @(posedge clk);
    #1;
    model_check();
  endtask

  task automatic idle_inputs();
    core_ready = 1'b0;
    flush      = 1'b0;
    flush_pc   = '0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_valid", core_valid, 0);
    chk("rst_pc", core_pc, 0);
    chk("rst_inst", core_inst, 0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    model_check();
    chk("first_req", mem_req, 1);
    chk("first_addr", mem_addr, RESET_PC);
  endtask

  typedef struct {
    bit          rdy;
    bit          ack;
    bit          fl;
    logic [31:0] fpc;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int          first_ack, first_valid, got, pops;
    logic [31:0] seen[4];
    logic [31:0] exp_seq[4];

    rst = 1'b0;
    idle_inputs();

    // ---- table: fill with instant acks, one pop restarts fetch, flush in IDLE
    tbl[0] = '{0, 1, 0, 32'h0,   1, 32'h00,  0, 32'h0};
    tbl[1] = '{0, 1, 0, 32'h0,   1, 32'h04,  1, 32'h0};
    tbl[2] = '{0, 1, 0, 32'h0,   1, 32'h08,  1, 32'h0};
    tbl[3] = '{0, 1, 0, 32'h0,   1, 32'h0C,  1, 32'h0};
    tbl[4] = '{1, 0, 0, 32'h0,   0, 32'h00,  1, 32'h0};
    tbl[5] = '{0, 1, 0, 32'h0,   1, 32'h10,  1, 32'h4};
    tbl[6] = '{0, 0, 1, 32'h203, 0, 32'h00,  1, 32'h4};
    tbl[7] = '{0, 0, 0, 32'h0,   0, 32'h00,  0, 32'h0};
    tbl[8] = '{0, 0, 0, 32'h0,   1, 32'h200, 0, 32'h0};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("tbl%0d_req", i), mem_req, tbl[i].e_req);
      if (tbl[i].e_req) chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_valid", i), core_valid, tbl[i].e_valid);
      chk($sformatf("tbl%0d_pc", i), core_pc, tbl[i].e_pc);
      chk($sformatf("tbl%0d_inst", i), core_inst, tbl[i].e_valid ? mem_word(tbl[i].e_pc) : 32'h0);
      $display("[TB] vec %0d req=%b addr=%h valid=%b pc=%h", i, mem_req, mem_addr, core_valid, core_pc);
      step(tbl[i].rdy, tbl[i].fl, tbl[i].fpc, tbl[i].ack);
    end

    // ---- ack one cycle after each request, core always ready
    do_reset();
    exp_seq = '{32'h0, 32'h4, 32'h8, 32'hC};
    first_ack   = -1;
    first_valid = -1;
    got         = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      if (core_valid) begin
        if (first_valid < 0) first_valid = c;
        seen[got] = core_pc;
        got++;
      end
      if (req_age >= 1 && mem_req && first_ack < 0) first_ack = c;
      step(1, 0, 0, req_age >= 1);
    end
    chk("t1_count", got, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_pc%0d", i), seen[i], exp_seq[i]);
      $display("[TB] seq pop %0d pc=%h", i, seen[i]);
    end
    chk("t1_latency", first_valid - first_ack, 1);

    // ---- flush while an ack is delayed three cycles
    do_reset();
    step(0, 0, 0, 0);
    step(0, 1, 32'h100, 0);
    chk("t3_held_req", mem_req, 1);
    chk("t3_held_addr", mem_addr, 32'h0);
    chk("t3_valid", core_valid, 0);
    step(0, 0, 0, 0);
    chk("t3_held_addr2", mem_addr, 32'h0);
    step(0, 0, 0, 1);
    chk("t3_drop_valid", core_valid, 0);
    chk("t3_idle_req", mem_req, 0);
    step(0, 0, 0, 0);
    chk("t3_new_req", mem_req, 1);
    chk("t3_new_addr", mem_addr, 32'h100);
    step(1, 0, 0, 1);
    chk("t3_core_valid", core_valid, 1);
    chk("t3_core_pc", core_pc, 32'h100);
    $display("[TB] flush-while-waiting: pc=%h", core_pc);

    // ---- flush coinciding with ack
    do_reset();
    step(0, 1, 32'h200, 1);
    chk("t4_valid", core_valid, 0);
    chk("t4_req", mem_req, 0);
    step(0, 0, 0, 0);
    chk("t4_addr", mem_addr, 32'h200);
    $display("[TB] flush-with-ack: next addr=%h", mem_addr);

    // ---- address wrap at the top of the space
    step(0, 1, 32'hFFFF_FFFE, 1);
    step(0, 0, 0, 0);
    chk("t5_addr_top", mem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 1);
    chk("t5_addr_wrap", mem_addr, 32'h0);
    chk("t5_core_pc", core_pc, 32'hFFFF_FFFC);
    $display("[TB] wrap: head=%h next addr=%h", core_pc, mem_addr);

    // ---- asynchronous reset in the middle of a cycle
    idle_inputs();
    #3;
    rst = 1'b0;
    #1;
    chk("t6_req_async", mem_req, 0);
    chk("t6_valid_async", core_valid, 0);
    #2;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    model_check();
    chk("t6_restart_req", mem_req, 1);
    chk("t6_restart_addr", mem_addr, RESET_PC);
    $display("[TB] async reset: restart addr=%h", mem_addr);

    // ---- randomized run against the model
    do_reset();
    pops = 0;
    for (int i = 0; i < 4000; i++) begin
      bit rdy;
      rdy = ((i / 500) % 2) ? ($urandom_range(9) < 3) : ($urandom_range(9) < 8);
      if (core_valid && rdy) pops++;
      step(rdy, $urandom_range(39) == 0, $urandom(), $urandom_range(9) < 4);
    end
    chk("rand_progress", pops > 200, 1);
    $display("[TB] random: %0d instructions delivered", pops);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
